// File: rtl/wts_noise_pkg.sv
// ---------------------------------------------------------------------------
// wts_noise_pkg
// Shared constants and types for the noise controller slice.
//   - register addresses decoded from the CPU bus
//   - controller state encoding
//   - frequency ceiling and sweep direction encoding
// ---------------------------------------------------------------------------
package wts_noise_pkg;

    localparam logic [1:0] NOISE_ADDR_FREQ  = 2'd0;
    localparam logic [1:0] NOISE_ADDR_MASK  = 2'd1;
    localparam logic [1:0] NOISE_ADDR_SWEEP = 2'd2;

    localparam logic [4:0] FREQ_MAX     = 5'd31;
    localparam logic       SWEEP_DIR_UP = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } noise_state_t;

endpackage

// File: rtl/wts_noise_controller_if.sv
// ---------------------------------------------------------------------------
// wts_noise_controller_if
// CPU register-write bus into the noise controller.
//   bus_wrreq    one-cycle write strobe
//   bus_address  register select (2 bits)
//   bus_wdata    write data (8 bits)
// Modports: master = register decoder side, slave = controller side.
// ---------------------------------------------------------------------------
interface wts_noise_controller_if;

    logic       bus_wrreq;
    logic [1:0] bus_address;
    logic [7:0] bus_wdata;

    modport master (
        output bus_wrreq,
        output bus_address,
        output bus_wdata
    );

    modport slave (
        input bus_wrreq,
        input bus_address,
        input bus_wdata
    );

endinterface

// File: rtl/wts_noise_sweep.sv
// ---------------------------------------------------------------------------
// wts_noise_sweep
// Sweep tick counter plus the frequency step / end-of-range logic.
// Ports:
//   clk, nreset   system clock, asynchronous active-low reset
//   active        one-cycle 3.579 MHz timing pulse
//   sweep_en      counter runs only while this is high (controller in SWEEP)
//   clr           clears the tick counter (register writes)
//   dir           0 = step up, 1 = step down
//   period        step every period+1 active pulses
//   freq          current frequency count
//   next_freq     frequency after the step (valid with step_valid)
//   step_valid    a step is due this cycle
//   sweep_done    end of range reached; sweep must stop
// Build option: WTS_NOISE_SWEEP_WRAP_EN makes the range wrap instead of
// saturating, and sweep_done is then never raised.
// ---------------------------------------------------------------------------
module wts_noise_sweep
    import wts_noise_pkg::*;
#(
    parameter int SWEEP_W = 6
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               active,
    input  logic               sweep_en,
    input  logic               clr,
    input  logic               dir,
    input  logic [SWEEP_W-1:0] period,
    input  logic [4:0]         freq,
    output logic [4:0]         next_freq,
    output logic               step_valid,
    output logic               sweep_done
);

    logic [SWEEP_W-1:0] cnt_q, cnt_d;
    logic               hit;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cnt_d      = cnt_q;
        next_freq  = freq;
        step_valid = 1'b0;
        sweep_done = 1'b0;
        hit        = sweep_en && active && (cnt_q == period);

        if (clr) begin
            cnt_d = '0;
        end else if (sweep_en && active) begin
            cnt_d = hit ? '0 : cnt_q + SWEEP_W'(1);
        end

        if (hit) begin
            if (dir == SWEEP_DIR_UP) begin
`ifdef WTS_NOISE_SWEEP_WRAP_EN
                next_freq  = freq + 5'd1;   // 31 + 1 wraps to 0 in 5 bits
                step_valid = 1'b1;
`else
                if (freq == FREQ_MAX) begin
                    sweep_done = 1'b1;
                end else begin
                    next_freq  = freq + 5'd1;
                    step_valid = 1'b1;
                end
`endif
            end else begin
`ifdef WTS_NOISE_SWEEP_WRAP_EN
                next_freq  = freq - 5'd1;   // 0 - 1 wraps to 31 in 5 bits
                step_valid = 1'b1;
`else
                if (freq == 5'd0) begin
                    sweep_done = 1'b1;
                end else begin
                    next_freq  = freq - 5'd1;
                    step_valid = 1'b1;
                end
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wts_noise_controller.sv
// ---------------------------------------------------------------------------
// wts_noise_controller
// Register-programmed sequencer for the shared noise generator. Holds the
// frequency count and per-channel noise mask, enables the generator while
// any channel takes noise, gates the noise bit per channel, and runs an
// optional automatic frequency sweep timed by the 3.579 MHz active pulse.
// Ports:
//   clk, nreset          system clock, asynchronous active-low reset
//   active               one-cycle 3.579 MHz timing pulse
//   bus                  CPU register-write bus (slave modport)
//   noise_in             noise bit from the generator
//   reg_frequency_count  frequency count to the generator
//   noise_enable         generator enable
//   ch_noise             per-channel gated noise, 1-cycle latency
//   sweep_busy           sweep is running
// Build option: WTS_NOISE_SWEEP_WRAP_EN (sweep wraps instead of saturating).
// ---------------------------------------------------------------------------
module wts_noise_controller
    import wts_noise_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SWEEP_W  = 6
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 active,
    wts_noise_controller_if.slave bus,
    input  logic                 noise_in,
    output logic [4:0]           reg_frequency_count,
    output logic                 noise_enable,
    output logic [CHANNELS-1:0]  ch_noise,
    output logic                 sweep_busy
);

    noise_state_t        state_q, state_d;
    logic [4:0]          freq_q, freq_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                sweep_en_q, sweep_en_d;
    logic                dir_q, dir_d;
    logic [SWEEP_W-1:0]  period_q, period_d;
    logic                noise_enable_q, noise_enable_d;
    logic                sweep_busy_q, sweep_busy_d;
    logic [CHANNELS-1:0] ch_noise_q, ch_noise_d;

    logic                cnt_clr;
    logic                run_sweep;
    logic [4:0]          next_freq;
    logic                step_valid;
    logic                sweep_done;
    logic [5:0]          wdata_period;

    assign wdata_period = bus.bus_wdata[5:0];

    // The counter only runs when the controller is and stays in SWEEP, so a
    // mask clear freezes it on the same cycle the state heads to IDLE.
    assign run_sweep = (state_q == SWEEP) && (state_d == SWEEP);

    wts_noise_sweep #(
        .SWEEP_W (SWEEP_W)
    ) u_sweep (
        .clk        (clk),
        .nreset     (nreset),
        .active     (active),
        .sweep_en   (run_sweep),
        .clr        (cnt_clr),
        .dir        (dir_q),
        .period     (period_q),
        .freq       (freq_q),
        .next_freq  (next_freq),
        .step_valid (step_valid),
        .sweep_done (sweep_done)
    );

    // Next-state: registers, sweep stepping and FSM.
    always_comb begin
        state_d    = state_q;
        freq_d     = freq_q;
        mask_d     = mask_q;
        sweep_en_d = sweep_en_q;
        dir_d      = dir_q;
        period_d   = period_q;
        cnt_clr    = 1'b0;

        if (step_valid) freq_d     = next_freq;
        if (sweep_done) sweep_en_d = 1'b0;

        // CPU writes override a coincident sweep step entirely.
        if (bus.bus_wrreq) begin
            case (bus.bus_address)
                NOISE_ADDR_FREQ: begin
                    freq_d     = bus.bus_wdata[4:0];
                    sweep_en_d = sweep_en_q;
                    cnt_clr    = 1'b1;
                end
                NOISE_ADDR_MASK: begin
                    mask_d = bus.bus_wdata[CHANNELS-1:0];
                end
                NOISE_ADDR_SWEEP: begin
                    freq_d     = freq_q;
                    sweep_en_d = bus.bus_wdata[7];
                    dir_d      = bus.bus_wdata[6];
                    period_d   = SWEEP_W'(wdata_period);
                    cnt_clr    = 1'b1;
                end
                default: ;  // reserved address: write ignored
            endcase
        end

        if (mask_q == '0)     state_d = IDLE;
        else if (sweep_en_q)  state_d = SWEEP;
        else                  state_d = RUN;
    end

    // Output flops track the state being entered so they change together
    // with state_q.
    always_comb begin
        noise_enable_d = (state_d != IDLE);
        sweep_busy_d   = (state_d == SWEEP);
        ch_noise_d     = (state_q == IDLE) ? '0 : ({CHANNELS{noise_in}} & mask_q);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            freq_q         <= '0;
            mask_q         <= '0;
            sweep_en_q     <= 1'b0;
            dir_q          <= 1'b0;
            period_q       <= '0;
            noise_enable_q <= 1'b0;
            sweep_busy_q   <= 1'b0;
            ch_noise_q     <= '0;
        end else begin
            state_q        <= state_d;
            freq_q         <= freq_d;
            mask_q         <= mask_d;
            sweep_en_q     <= sweep_en_d;
            dir_q          <= dir_d;
            period_q       <= period_d;
            noise_enable_q <= noise_enable_d;
            sweep_busy_q   <= sweep_busy_d;
            ch_noise_q     <= ch_noise_d;
        end
    end

    assign reg_frequency_count = freq_q;
    assign noise_enable        = noise_enable_q;
    assign sweep_busy          = sweep_busy_q;
    assign ch_noise            = ch_noise_q;

endmodule

// File: tb/tb_wts_noise_controller.sv
// ---------------------------------------------------------------------------
// tb_wts_noise_controller
// Directed bench for wts_noise_controller with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// active is pulsed one clock in six, matching 21.477 MHz / 3.579 MHz.
// ---------------------------------------------------------------------------
module tb_wts_noise_controller;

    localparam int CHANNELS = 4;
    localparam int SWEEP_W  = 6;

    logic                clk;
    logic                nreset;
    logic                active;
    logic                noise_in;
    logic [4:0]          reg_frequency_count;
    logic                noise_enable;
    logic [CHANNELS-1:0] ch_noise;
    logic                sweep_busy;

    int vectors;
    int miscompares;

    wts_noise_controller_if bus_if ();

    wts_noise_controller #(
        .CHANNELS (CHANNELS),
        .SWEEP_W  (SWEEP_W)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .active              (active),
        .bus                 (bus_if),
        .noise_in            (noise_in),
        .reg_frequency_count (reg_frequency_count),
        .noise_enable        (noise_enable),
        .ch_noise            (ch_noise),
        .sweep_busy          (sweep_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        bus_if.bus_wrreq   = 1'b1;
        bus_if.bus_address = addr;
        bus_if.bus_wdata   = data;
        cyc();
        bus_if.bus_wrreq   = 1'b0;
    endtask

    // One active pulse followed by five quiet clocks.
    task automatic act_pulse();
        active = 1'b1;
        cyc();
        active = 1'b0;
        repeat (5) cyc();
    endtask

    task automatic act_pulses(input int n);
        for (int i = 0; i < n; i++) act_pulse();
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        nreset             = 1'b0;
        active             = 1'b0;
        noise_in           = 1'b0;
        bus_if.bus_wrreq   = 1'b0;
        bus_if.bus_address = 2'd0;
        bus_if.bus_wdata   = 8'h00;

        // Reset values
        #12;
        check("rst_freq",   reg_frequency_count, 5'h00);
        check("rst_enable", noise_enable, 1'b0);
        check("rst_ch",     ch_noise, 4'h0);
        check("rst_busy",   sweep_busy, 1'b0);
        nreset = 1'b1;
        cyc();

        // Mask write, enable latency, channel gating
        bus_write(2'd1, 8'h05);
        check("en_before",  noise_enable, 1'b0);
        cyc();
        check("en_after",   noise_enable, 1'b1);
        check("busy_run",   sweep_busy, 1'b0);
        noise_in = 1'b1;
        cyc();
        check("ch_0101",    ch_noise, 4'b0101);
        noise_in = 1'b0;
        cyc();
        check("ch_zero",    ch_noise, 4'b0000);

        // Sweep up, period 3: one step per 4 active pulses
        bus_write(2'd0, 8'h10);
        bus_write(2'd1, 8'h01);
        bus_write(2'd2, 8'h83);
        cyc();
        check("busy_sweep", sweep_busy, 1'b1);
        act_pulses(3);
        check("p3_hold",    reg_frequency_count, 5'h10);
        act_pulse();
        check("p3_step1",   reg_frequency_count, 5'h11);
        act_pulses(3);
        check("p3_hold2",   reg_frequency_count, 5'h11);
        act_pulse();
        check("p3_step2",   reg_frequency_count, 5'h12);

        // Reserved address ignored
        bus_write(2'd3, 8'hFF);
        cyc();
        check("rsvd_freq",  reg_frequency_count, 5'h12);
        check("rsvd_mask",  noise_enable, 1'b1);

        // Top of range, period 0
        bus_write(2'd0, 8'h1E);
        bus_write(2'd2, 8'h80);
        cyc();
        act_pulse();
        check("top_1f",     reg_frequency_count, 5'h1F);
        act_pulse();
`ifdef WTS_NOISE_SWEEP_WRAP_EN
        check("top_wrap",   reg_frequency_count, 5'h00);
        check("top_busy",   sweep_busy, 1'b1);
`else
        check("top_sat",    reg_frequency_count, 5'h1F);
        check("top_busy",   sweep_busy, 1'b0);
        check("top_run_en", noise_enable, 1'b1);
`endif

        // Bottom of range, down, period 0
        bus_write(2'd0, 8'h01);
        bus_write(2'd2, 8'hC0);
        cyc();
        check("dn_busy",    sweep_busy, 1'b1);
        act_pulse();
        check("dn_00",      reg_frequency_count, 5'h00);
        act_pulse();
`ifdef WTS_NOISE_SWEEP_WRAP_EN
        check("bot_wrap",   reg_frequency_count, 5'h1F);
        check("bot_busy",   sweep_busy, 1'b1);
`else
        check("bot_sat",    reg_frequency_count, 5'h00);
        check("bot_busy",   sweep_busy, 1'b0);
`endif

        // CPU freq write coinciding with a step: write wins, counter cleared
        bus_write(2'd0, 8'h05);
        bus_write(2'd2, 8'h82);
        cyc();
        act_pulses(2);
        check("col_pre",    reg_frequency_count, 5'h05);
        active             = 1'b1;
        bus_if.bus_wrreq   = 1'b1;
        bus_if.bus_address = 2'd0;
        bus_if.bus_wdata   = 8'h08;
        cyc();
        active             = 1'b0;
        bus_if.bus_wrreq   = 1'b0;
        check("col_cpu",    reg_frequency_count, 5'h08);
        repeat (5) cyc();
        act_pulses(2);
        check("col_hold",   reg_frequency_count, 5'h08);
        act_pulse();
        check("col_step",   reg_frequency_count, 5'h09);

        // Sweep-register write coinciding with a step: write wins
        bus_write(2'd2, 8'h80);
        cyc();
        active             = 1'b1;
        bus_if.bus_wrreq   = 1'b1;
        bus_if.bus_address = 2'd2;
        bus_if.bus_wdata   = 8'h81;
        cyc();
        active             = 1'b0;
        bus_if.bus_wrreq   = 1'b0;
        check("sw_col",     reg_frequency_count, 5'h09);
        repeat (5) cyc();

        // Mask cleared mid-sweep: IDLE, counter frozen, then resume
        bus_write(2'd0, 8'h04);
        act_pulse();                       // counter 0 -> 1 (period 1)
        check("mk_pre",     reg_frequency_count, 5'h04);
        noise_in = 1'b1;
        bus_write(2'd1, 8'h00);
        cyc();
        check("mk_en",      noise_enable, 1'b0);
        check("mk_busy",    sweep_busy, 1'b0);
        cyc();
        check("mk_ch",      ch_noise, 4'h0);
        act_pulses(3);
        check("mk_frozen",  reg_frequency_count, 5'h04);
        bus_write(2'd1, 8'h02);
        cyc();
        check("mk_resume",  sweep_busy, 1'b1);
        act_pulse();                       // frozen counter == period: step
        check("mk_step",    reg_frequency_count, 5'h05);
        check("mk_ch2",     ch_noise, 4'b0010);

        // Asynchronous reset mid-sweep
        #2;
        nreset = 1'b0;
        #1;
        check("ar_freq",    reg_frequency_count, 5'h00);
        check("ar_enable",  noise_enable, 1'b0);
        check("ar_ch",      ch_noise, 4'h0);
        check("ar_busy",    sweep_busy, 1'b0);
        #2;
        nreset = 1'b1;
        cyc();
        cyc();
        check("ar_idle",    noise_enable, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
